// File: rtl/branch_pkg.sv
// branch_pkg: entry layout and constants shared by the branch resolve queue.
package branch_pkg;
    localparam int BRQ_PC_W = 32;
    localparam int PC_INC = 4;

    typedef struct packed {
        logic [BRQ_PC_W-1:0] pc;
        logic                pred_taken;
        logic [BRQ_PC_W-1:0] pred_tgt;
    } brq_entry_t;
endpackage

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order in-flight branch queue; resolves the oldest
// branch, drives predictor update and raises a redirect on mispredict.
module branch_resolve_queue
    import branch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = BRQ_PC_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [PC_W-1:0]          enq_pc,
    input  logic                     enq_pred_taken,
    input  logic [PC_W-1:0]          enq_pred_tgt,
    input  logic                     res_valid,
    input  logic                     res_taken,
    input  logic [PC_W-1:0]          res_tgt,
    output logic                     upd_valid,
    output logic                     upd_taken,
    output logic [PC_W-1:0]          upd_pc,
    output logic                     redirect,
    output logic [PC_W-1:0]          redirect_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     underflow_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    brq_entry_t mem [DEPTH];
    brq_entry_t head;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic empty, full, push, pop, mispredict;

    assign head = mem[rd_ptr[AW-1:0]];
    assign empty = rd_ptr == wr_ptr;
    assign full = rd_ptr[AW-1:0] == wr_ptr[AW-1:0] && rd_ptr[AW] != wr_ptr[AW];
    assign enq_ready = !full;
    assign count = wr_ptr - rd_ptr;
    assign pop = res_valid && !empty && !flush;
    // Directions agree here, so only a taken branch can still miss on target.
    assign mispredict = head.pred_taken != res_taken || (res_taken && head.pred_tgt != res_tgt);
    // A push alongside a mispredicting resolve is younger and gets squashed.
    assign push = enq_valid && enq_ready && !flush && !(pop && mispredict);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= brq_entry_t'{pc: enq_pc, pred_taken: enq_pred_taken, pred_tgt: enq_pred_tgt};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            upd_valid     <= 1'b0;
            upd_taken     <= 1'b0;
            upd_pc        <= '0;
            redirect      <= 1'b0;
            redirect_pc   <= '0;
            underflow_err <= 1'b0;
        end else begin
            upd_valid <= pop;
            redirect  <= pop && mispredict;
            if (pop) begin
                upd_taken   <= res_taken;
                upd_pc      <= head.pc;
                redirect_pc <= res_taken ? res_tgt : head.pc + PC_W'(PC_INC);
            end
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else begin
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                if (pop && mispredict) wr_ptr <= rd_ptr + PW'(1);
                else if (push) wr_ptr <= wr_ptr + PW'(1);
                if (res_valid && empty) underflow_err <= 1'b1;
            end
        end
    end
endmodule
